c1908_resp_checker: RTL and testbench

//  Receive-side checker for the c1908 vector stream. The driver applies one
//  33-bit input vector per cycle, and this block accepts the matching 25-bit
//  DUT response. It compares each response with a golden word and counts

---
 rtl/c1908_tb_pkg.sv | 24 ++
 rtl/c1908_misr.sv | 41 ++++
 rtl/c1908_resp_checker.sv | 131 +++++++++++++
 tb/tb_c1908_resp_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/c1908_tb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : c1908_tb_pkg
//  Brief    : Shared types and constants for the c1908 vector-stream checkers
//  Revision : 1.0 - initial release
// ============================================================================
package c1908_tb_pkg;

    // Checker run state; 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int C1908_IN_W    = 33;
    localparam int C1908_OUT_W   = 25;
    localparam int C1908_VEC_LEN = 64;

    // x^25 + x^3 + 1
    localparam logic [C1908_OUT_W-1:0] C1908_MISR_POLY = 25'h0000009;

endpackage : c1908_tb_pkg
`default_nettype wire

// File: rtl/c1908_misr.sv
`default_nettype none
// ============================================================================
//  Module   : c1908_misr
//  Brief    : Multiple-input signature register (Galois form, shift toward MSB)
//  Revision : 1.0 - initial release
// ============================================================================
module c1908_misr #(
    parameter int           W    = 25,
    parameter logic [W-1:0] POLY = 25'h0000009
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    // Next signature: shift left, fold MSB back through the taps, absorb d
    always_comb begin
        sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ d;
    end

    // Signature register; clear has priority over compaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule : c1908_misr
`default_nettype wire

// File: rtl/c1908_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : c1908_resp_checker
//  Brief    : Receive-side response checker: golden compare, saturating error
//             count, first-failure index capture and MISR compaction
//  Revision : 1.0 - initial release
// ============================================================================
module c1908_resp_checker
    import c1908_tb_pkg::*;
#(
    parameter int                   OUT_WIDTH  = C1908_OUT_W,
    parameter int                   VEC_LENGTH = C1908_VEC_LEN,
    parameter int                   IDX_W      = 6,
    parameter int                   ERR_W      = 8,
    parameter logic [OUT_WIDTH-1:0] MISR_POLY  = C1908_MISR_POLY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 resp_valid,
    input  logic [OUT_WIDTH-1:0] resp_data,
    input  logic [OUT_WIDTH-1:0] exp_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 first_fail_valid,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic [OUT_WIDTH-1:0] signature
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(VEC_LENGTH - 1);
    localparam logic [ERR_W-1:0] C_ERR_MAX  = {ERR_W{1'b1}};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [ERR_W-1:0]   err_q,   err_d;
    logic               ffv_q,   ffv_d;
    logic [IDX_W-1:0]   ffi_q,   ffi_d;

    logic               run_clr;
    logic               accept;
    logic               mismatch;

    // A start outside RUN opens a new run; its companion response is dropped
    assign run_clr  = start && (state_q != ST_RUN);
    assign accept   = (state_q == ST_RUN) && resp_valid;
    assign mismatch = |(resp_data ^ exp_data);

    // Next-state logic: start enters RUN, final accepted response enters DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (accept && (idx_q == C_LAST_IDX)) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next values of index, error counter and first-failure capture
    always_comb begin
        idx_d = idx_q;
        err_d = err_q;
        ffv_d = ffv_q;
        ffi_d = ffi_q;
        if (run_clr) begin
            idx_d = '0;
            err_d = '0;
            ffv_d = 1'b0;
            ffi_d = '0;
        end else if (accept) begin
            // RUN leaves at the last index, so idx never wraps
            idx_d = idx_q + IDX_W'(1);
            if (mismatch) begin
                if (err_q != C_ERR_MAX) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffi_d = idx_q;
                end
            end
        end
    end

    // Counter and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            err_q <= '0;
            ffv_q <= 1'b0;
            ffi_q <= '0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
            ffv_q <= ffv_d;
            ffi_q <= ffi_d;
        end
    end

    c1908_misr #(
        .W    (OUT_WIDTH),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_clr),
        .en    (accept),
        .d     (resp_data),
        .sig   (signature)
    );

    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign pass             = (state_q == ST_DONE) && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule : c1908_resp_checker
`default_nettype wire

// File: tb/tb_c1908_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c1908_resp_checker
//  Brief    : Self-checking bench with a behavioural run model; a second
//             instance with a 2-bit error counter exercises saturation
//  Revision : 1.0 - initial release
// ============================================================================
module tb_c1908_resp_checker;

    localparam int W = 25;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          resp_valid;
    logic [W-1:0]  resp_data;
    logic [W-1:0]  exp_data;

    logic          busy, done, pass, ffv;
    logic [7:0]    err_count;
    logic [5:0]    ffi;
    logic [W-1:0]  signature;

    logic          b_busy, b_done, b_pass, b_ffv;
    logic [1:0]    b_err;
    logic [5:0]    b_ffi;
    logic [W-1:0]  b_sig;

    always #5 clk = ~clk;

    c1908_resp_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
        .resp_data(resp_data), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(ffv), .first_fail_idx(ffi), .signature(signature)
    );

    c1908_resp_checker #(.ERR_W(2)) u_dut_e2 (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
        .resp_data(resp_data), .exp_data(exp_data),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_fail_valid(b_ffv), .first_fail_idx(b_ffi), .signature(b_sig)
    );

    // ---------------- reference model ----------------
    bit          m_run, m_done, m_ffv;
    int          m_idx, m_err8, m_err2, m_ffi;
    logic [W-1:0] m_sig;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [W-1:0] misr_next(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] sh;
        sh = s << 1;
        if (s[W-1]) sh = sh ^ 25'h0000009;
        return sh ^ d;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_ffv = 0;
        m_idx = 0; m_err8 = 0; m_err2 = 0; m_ffi = 0; m_sig = '0;
    endtask

    task automatic model_edge(input bit st, input bit v, input logic [W-1:0] r, input logic [W-1:0] e);
        if (!m_run) begin
            if (st) begin
                model_reset();
                m_run = 1;
            end
        end else if (v) begin
            if (r != e) begin
                if (m_err8 < 255) m_err8++;
                if (m_err2 < 3)   m_err2++;
                if (!m_ffv) begin
                    m_ffv = 1;
                    m_ffi = m_idx;
                end
            end
            m_sig = misr_next(m_sig, r);
            if (m_idx == 63) begin
                m_run  = 0;
                m_done = 1;
            end
            m_idx++;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy",  32'(busy),      32'(m_run));
        chk("done",  32'(done),      32'(m_done));
        chk("pass",  32'(pass),      32'(m_done && m_err8 == 0));
        chk("err8",  32'(err_count), 32'(m_err8));
        chk("ffv",   32'(ffv),       32'(m_ffv));
        chk("ffi",   32'(ffi),       32'(m_ffi));
        chk("sig",   32'(signature), 32'(m_sig));
        chk("e2_err",  32'(b_err),   32'(m_err2));
        chk("e2_pass", 32'(b_pass),  32'(m_done && m_err2 == 0));
        chk("e2_ffi",  32'(b_ffi),   32'(m_ffi));
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it
    task automatic cycle(input bit st, input bit v, input logic [W-1:0] r, input logic [W-1:0] e);
        start = st; resp_valid = v; resp_data = r; exp_data = e;
        @(posedge clk);
        model_edge(st, v, r, e);
        #1;
        check_all();
    endtask

    task automatic begin_run();
        // start with a random companion response that must not be accepted
        cycle(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    endtask

    // mode 0 clean, 1 flips bit 0 at idx 5/40, 2 all mismatch, 3 random with stalls
    task automatic run_vecs(input int mode, input int base, input int count);
        logic [W-1:0] r, e;
        for (int i = 0; i < count; i++) begin
            if (mode == 3) begin
                while ($urandom_range(0, 3) == 0) cycle(1'($urandom_range(0, 1)), 1'b0, W'($urandom), W'($urandom));
            end
            e = W'($urandom);
            r = e;
            case (mode)
                1: if ((base + i) == 5 || (base + i) == 40) r = e ^ 25'h1;
                2: r = e ^ (W'(1) << $urandom_range(0, W - 1));
                3: if ($urandom_range(0, 7) == 0) r = e ^ W'($urandom_range(1, 255));
                default: ;
            endcase
            cycle(1'b0, 1'b1, r, e);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; resp_valid = 1'b0; resp_data = '0; exp_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // valid while idle is ignored
        cycle(1'b0, 1'b1, W'($urandom), W'($urandom));

        // 1: clean run
        begin_run();
        run_vecs(0, 0, 64);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err",  32'(err_count), 32'd0);
        chk("t1_ffv",  32'(ffv), 32'd0);

        // 2: MISR seed behaviour
        begin_run();
        cycle(1'b0, 1'b1, 25'h1, 25'h1);
        chk("t2_sig1", 32'(signature), 32'h1);
        cycle(1'b0, 1'b1, 25'h0, 25'h0);
        chk("t2_sig2", 32'(signature), 32'h2);
        run_vecs(0, 2, 62);

        // 3: two single-bit failures
        begin_run();
        run_vecs(1, 0, 64);
        chk("t3_err",  32'(err_count), 32'd2);
        chk("t3_ffi",  32'(ffi), 32'd5);
        chk("t3_pass", 32'(pass), 32'd0);

        // 4: every response wrong
        begin_run();
        run_vecs(2, 0, 64);
        chk("t4_err2", 32'(b_err), 32'd3);
        chk("t4_err8", 32'(err_count), 32'd64);
        chk("t4_ffi",  32'(ffi), 32'd0);

        // valid in DONE ignored
        cycle(1'b0, 1'b1, W'($urandom), W'($urandom));

        // 5: stall after idx 30, start pulse mid-run
        begin_run();
        run_vecs(0, 0, 31);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, W'($urandom), W'($urandom));
        chk("t5_busy", 32'(busy), 32'd1);
        cycle(1'b1, 1'b1, 25'h1234, 25'h1234);
        run_vecs(0, 32, 32);
        chk("t5_done", 32'(done), 32'd1);

        // 6: reset at idx 20
        begin_run();
        run_vecs(3, 0, 20);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; resp_valid = 1'b0;
        rst_n = 1'b1;
        begin_run();
        run_vecs(0, 0, 64);
        chk("t6_pass", 32'(pass), 32'd1);

        // random runs, then restart from DONE clears results
        for (int k = 0; k < 3; k++) begin
            begin_run();
            run_vecs(3, 0, 64);
        end
        cycle(1'b1, 1'b0, W'($urandom), W'($urandom));
        chk("t6_clr_err", 32'(err_count), 32'd0);
        chk("t6_clr_sig", 32'(signature), 32'd0);
        chk("t6_clr_ffv", 32'(ffv), 32'd0);
        chk("t6_clr_busy", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_c1908_resp_checker
`default_nettype wire
